ad1_spi_slave: RTL and testbench

- SPI responder that emulates the 16-bit AD1 ADC on the slave side of the link.
- Receives cs/sclk from the AD1 SPI master, shifts a 16-bit word out on sdo MSB-first, and takes words from an FPGA-side valid/ready source.
- Used for closed-loop bring-up and verification of the acquisition chain: the master reads back known patterns without real ADC hardware.
- All logic runs on clk_100M; cs and sclk are treated as asynchronous inputs and synchronized.

---
 rtl/ad1_spi_slave.sv | 127 ++++++++++++
 tb/tb_ad1_spi_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ad1_spi_slave.sv
// SPI responder emulating the 16-bit AD1 ADC: shifts a word out on sdo per cs frame.
// Words come from a one-entry valid/ready buffer; on underrun the last sent word is repeated.
module ad1_spi_slave #(
  parameter int          SYNC_STAGES          = 2,
  parameter int          BITS_PER_TRANSACTION = 16,
  parameter logic [15:0] IDLE_WORD            = 16'h0000
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        sclk,
  output logic        sdo,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cs_q;
  logic                   sclk_q;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_rise;
  logic                   tx_wr;

  state_t      state;
  logic [15:0] hold;
  logic [15:0] last_word;
  logic [15:0] shreg;
  logic [7:0]  bitcnt;

  // Both lines idle high, so the synchronizers reset high to avoid a false edge.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign tx_wr     = tx_valid & tx_ready;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdo        <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      underrun   <= 1'b0;
      hold       <= '0;
      last_word  <= IDLE_WORD;
      shreg      <= '0;
      bitcnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      underrun   <= 1'b0;
      // A write needs tx_ready=1 (buffer empty) and a consume needs it full, so they never collide.
      if (tx_wr) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (cs_fall) begin
            state  <= SHIFT;
            busy   <= 1'b1;
            bitcnt <= '0;
            if (!tx_ready) begin
              shreg     <= hold;
              last_word <= hold;
              sdo       <= hold[15];
              tx_ready  <= 1'b1;
            end else begin
              shreg    <= last_word;
              sdo      <= last_word[15];
              underrun <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Zero fill makes sdo drop to 0 after the last data bit without extra logic.
          if (sclk_rise) begin
            shreg <= {shreg[14:0], 1'b0};
            sdo   <= shreg[14];
            if (bitcnt != 8'hFF) bitcnt <= bitcnt + 8'd1;
          end
          if (cs_rise) state <= DONE;
        end
        DONE: begin
          frame_done <= (bitcnt == 8'(BITS_PER_TRANSACTION));
          frame_err  <= (bitcnt != 8'(BITS_PER_TRANSACTION));
          bitcnt     <= '0;
          busy       <= 1'b0;
          sdo        <= 1'b0;
          shreg      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad1_spi_slave.sv
// Bench for ad1_spi_slave: drives an SPI master and an FPGA word source, compares against a buffer model.
module tb_ad1_spi_slave;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        cs       = 1'b1;
  logic        sclk     = 1'b1;
  logic        sdo;
  logic [15:0] tx_data  = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;

  int cnt_done  = 0;
  int cnt_err   = 0;
  int cnt_under = 0;

  // Reference model: one-entry buffer plus the word repeated on underrun.
  logic        m_full = 1'b0;
  logic [15:0] m_buf  = '0;
  logic [15:0] m_last = 16'h0000;

  ad1_spi_slave #(
    .SYNC_STAGES(2),
    .BITS_PER_TRANSACTION(16),
    .IDLE_WORD(16'h0000)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .cs        (cs),
    .sclk      (sclk),
    .sdo       (sdo),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .underrun  (underrun)
  );

  always #5 clk_100M = ~clk_100M;

  always @(posedge clk_100M) begin
    if (frame_done) cnt_done  <= cnt_done + 1;
    if (frame_err)  cnt_err   <= cnt_err + 1;
    if (underrun)   cnt_under <= cnt_under + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic load_word(input logic [15:0] w);
    int waited = 0;
    while (!tx_ready && waited < 50) begin
      nclk(1);
      waited++;
    end
    check("load_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    nclk(1);
    tx_valid = 1'b0;
    m_full   = 1'b1;
    m_buf    = w;
  endtask

  // One master transaction: nbits sclk rises, 5 clocks per bit, sample during sclk low.
  // sim_load presents a word in the very cycle the responder acts on cs_fall.
  task automatic run_frame(input string tag, input int nbits, input bit sim_load, input logic [15:0] sim_word);
    logic [31:0] rd;
    logic [15:0] word;
    logic [63:0] stream;
    bit          exp_under;
    int          d0, e0, u0;
    rd = '0;
    d0 = cnt_done; e0 = cnt_err; u0 = cnt_under;
    exp_under = !m_full;
    word      = m_full ? m_buf : m_last;
    m_last    = word;
    m_full    = 1'b0;
    cs = 1'b0;
    if (sim_load) begin
      nclk(2);
      tx_data  = sim_word;
      tx_valid = 1'b1;
      nclk(1);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_buf    = sim_word;
      nclk(3);
    end else begin
      nclk(6);
    end
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      nclk(3);
      rd   = {rd[30:0], sdo};
      sclk = 1'b1;
      nclk(2);
    end
    nclk(3);
    cs = 1'b1;
    nclk(12);
    stream = {word, 48'h0};
    check({tag, "_data"}, rd, 32'(stream >> (64 - nbits)));
    check({tag, "_done"}, 32'(cnt_done - d0), (nbits == 16) ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(cnt_err - e0), (nbits != 16) ? 32'd1 : 32'd0);
    check({tag, "_under"}, 32'(cnt_under - u0), 32'(exp_under));
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(tx_ready), 32'(!m_full));
    check({tag, "_sdo_idle"}, 32'(sdo), 32'd0);
  endtask

  task automatic reset_mid_frame();
    cs = 1'b0;
    nclk(6);
    for (int i = 0; i < 9; i++) begin
      sclk = 1'b0;
      nclk(3);
      sclk = 1'b1;
      nclk(2);
    end
    sclk  = 1'b0;
    nclk(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sdo", 32'(sdo), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    cs   = 1'b1;
    sclk = 1'b1;
    m_full = 1'b0;
    m_last = 16'h0000;
    nclk(3);
    rst_n = 1'b1;
    nclk(12);
    check("rst_mid_no_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int nb;
    nclk(3);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", {29'd0, frame_done, frame_err, underrun}, 32'd0);
    rst_n = 1'b1;
    nclk(4);

    run_frame("idle_word", 16, 1'b0, 16'h0);

    load_word(16'hA5C3);
    check("ready_drop", 32'(tx_ready), 32'd0);
    run_frame("single", 16, 1'b0, 16'h0);

    load_word(16'h0001); run_frame("b2b_0", 16, 1'b0, 16'h0);
    load_word(16'h8000); run_frame("b2b_1", 16, 1'b0, 16'h0);
    load_word(16'hFFFF); run_frame("b2b_2", 16, 1'b0, 16'h0);

    load_word(16'h1234); run_frame("pre_under", 16, 1'b0, 16'h0);
    run_frame("underrun", 16, 1'b0, 16'h0);

    load_word(16'h9999); run_frame("abort", 7, 1'b0, 16'h0);
    load_word(16'h5A5A); run_frame("after_abort", 16, 1'b0, 16'h0);

    reset_mid_frame();
    load_word(16'hC0DE); run_frame("after_rst", 16, 1'b0, 16'h0);

    run_frame("sim_load", 16, 1'b1, 16'h7777);
    run_frame("sim_next", 16, 1'b0, 16'h0);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) != 0) load_word(16'($urandom));
      case ($urandom_range(0, 4))
        0:       nb = $urandom_range(0, 15);
        1:       nb = $urandom_range(17, 24);
        default: nb = 16;
      endcase
      run_frame("rand", nb, 1'b0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
